// File: rtl/fetch_pkg.sv
// Shared encodings for the instruction-fetch stage:
// next-PC source selects, FSM states and default constants.
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JUMP   = 2'b10,
    PC_HOLD   = 2'b11
  } pc_src_e;

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } fetch_state_e;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [5:0]  DEF_HALT_OP  = 6'b111111;

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: sequential, PC-relative branch,
// or pseudo-direct jump, all modulo 2^32.
module next_pc_mux
  import fetch_pkg::*;
(
  input  logic [31:0] curPC,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  output logic [31:0] pcPlus4,
  output logic [31:0] nextPC
);

  logic [31:0] w_br_off;

  assign pcPlus4  = curPC + 32'd4;
  // word offset to byte offset; top bits fall off
  assign w_br_off = {immExt[29:0], 2'b00};

  always_comb begin
    nextPC = curPC;
    unique case (PCSrc)
      PC_SEQ:    nextPC = pcPlus4;
      PC_BRANCH: nextPC = pcPlus4 + w_br_off;
      PC_JUMP:   nextPC = {pcPlus4[31:28], jumpAddr, 2'b00};
      PC_HOLD:   nextPC = curPC;
      default:   nextPC = curPC;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, BOOT/RUN/HALT control,
// ROM strobe/address drive and retired-instruction counter.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [5:0]  HALT_OP  = DEF_HALT_OP
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        PCWre,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] immExt,
  input  logic [25:0] jumpAddr,
  output logic        romRd,
  output logic [31:0] romAddr,
  input  logic [31:0] romData,
  output logic [31:0] instr,
  output logic [31:0] curPC,
  output logic [31:0] pcPlus4,
  output logic        instValid,
  output logic        halted,
  output logic [31:0] retired
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  r_retired;
  logic [31:0]  w_next_pc;
  logic [31:0]  w_pc_plus4;
  logic         w_is_halt;
  logic         w_pc_we;
  logic         w_ret_inc;

  next_pc_mux u_next_pc_mux (
    .curPC    (r_pc),
    .PCSrc    (PCSrc),
    .immExt   (immExt),
    .jumpAddr (jumpAddr),
    .pcPlus4  (w_pc_plus4),
    .nextPC   (w_next_pc)
  );

  assign w_is_halt = (romData[31:26] == HALT_OP);

  always_comb begin
    w_state_nxt = r_state;
    romRd       = 1'b1;
    instr       = 32'h0;
    instValid   = 1'b0;
    halted      = 1'b0;
    w_pc_we     = 1'b0;
    w_ret_inc   = 1'b0;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        romRd     = 1'b0;
        instr     = romData;
        instValid = 1'b1;
        // halt wins over any PC write in the same cycle
        if (w_is_halt) begin
          w_state_nxt = ST_HALT;
          w_ret_inc   = 1'b1;
        end else if (PCWre && (PCSrc != PC_HOLD)) begin
          w_pc_we   = 1'b1;
          w_ret_inc = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state   <= ST_BOOT;
      r_pc      <= RESET_PC;
      r_retired <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pc_we)
        r_pc <= w_next_pc;
      if (w_ret_inc && (r_retired != 32'hFFFF_FFFF))
        r_retired <= r_retired + 32'd1;
    end
  end

  assign curPC   = r_pc;
  assign romAddr = r_pc;
  assign pcPlus4 = w_pc_plus4;
  assign retired = r_retired;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-fetch stage of the single-cycle CPU: owns the program counter, drives the instruction ROM's read strobe and address, and presents the fetched word to decode. Computes the next PC from sequential, branch and jump sources under control-unit selection. Detects the halt opcode, freezes fetch, and counts retired instructions for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_OP, 6'b111111, opcode (instr[31:26]) that halts fetch
- CLK  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- PCWre  in  1  PC write enable from control unit
- PCSrc  in  2  next-PC select: 00 seq, 01 branch, 10 jump, 11 hold
- immExt  in  32  sign-extended branch offset, in words
- jumpAddr  in  26  instr[25:0] jump target field
- romRd  out  1  ROM read strobe, active-low (0 = read)
- romAddr  out  32  ROM byte address
- romData  in  32  ROM read data, combinational from romAddr
- instr  out  32  fetched instruction to decode
- curPC  out  32  current PC
- pcPlus4  out  32  curPC + 4
- instValid  out  1  instr is a live instruction this cycle
- halted  out  1  fetch frozen by halt opcode
- retired  out  32  retired-instruction count

## Operation
- One clock domain, CLK; Reset is asynchronous, active-low.
- FSM states: BOOT, RUN, HALT.
- BOOT: entered on Reset assertion. romRd=1, instValid=0, instr=0, halted=0. PC held. Next edge -> RUN unconditionally.
- RUN: romRd=0, romAddr=curPC, instr=romData, instValid=1.
  - instr[31:26]==HALT_OP: next edge -> HALT, PC not written, retired += 1; PCWre/PCSrc ignored.
  - Else, on edge with PCWre=1 and PCSrc!=11: PC <= nextPC, retired += 1.
  - PCWre=0 or PCSrc=11: PC and retired unchanged (stall).
- HALT: romRd=1, instValid=0, instr=0, halted=1, PC and retired frozen. Exit only via Reset.
- nextPC, 32-bit modulo 2^32 arithmetic:
  - 00: pcPlus4.
  - 01: pcPlus4 + (immExt << 2); upper bits of immExt shifted out are discarded.
  - 10: {pcPlus4[31:28], jumpAddr, 2'b00}.
- Targets are word-aligned by construction; PC[1:0] stays 00 if RESET_PC[1:0]==00.
- pcPlus4 wraps: curPC 32'hFFFF_FFFC -> pcPlus4 32'h0000_0000.
- retired saturates at 32'hFFFF_FFFF; no wrap.
- Reset values: curPC=RESET_PC, romAddr=RESET_PC, pcPlus4=RESET_PC+4, romRd=1, instr=0, instValid=0, halted=0, retired=0, state=BOOT.

## Timing
- Reset assertion takes effect immediately, mid-cycle included; all outputs reach reset values without waiting for CLK.
- First rising edge after Reset deasserts: BOOT -> RUN, no PC write. Fetch of RESET_PC is visible in the following cycle.
- romAddr/curPC/pcPlus4 are derived from registered PC; they change only after a CLK edge or Reset.
- romData -> instr: zero-cycle combinational path.
- PC update latency: 1 cycle. nextPC is sampled at the edge where PCWre=1.
- Halt takes priority over simultaneous PCWre=1; the halting edge writes neither PC nor any branch target.
- halted rises one cycle after the halt opcode is presented.

## Structure
- Package fetch_pkg: PCSrc encodings (PC_SEQ, PC_BRANCH, PC_JUMP, PC_HOLD), FSM state enum, default RESET_PC and HALT_OP constants.
- Sub-module next_pc_mux: purely combinational; inputs curPC, PCSrc, immExt, jumpAddr; outputs pcPlus4 and nextPC.
- Top holds PC register, FSM, retired counter, and ROM/decode output muxing.

## Test plan
- Reset release, PCWre=1, PCSrc=00, ROM holding non-halt words -> romRd=1 for one cycle; then romAddr sequence 0,4,8,12; retired increments 1 per cycle.
- At PC=8, PCSrc=01, immExt=32'hFFFF_FFFE -> next PC=4. At PC=4, immExt=3 -> next PC=20.
- At PC=32'h1000_0010, PCSrc=10, jumpAddr=26'h000_0040 -> next PC=32'h1000_0100.
- PCWre=0 for 3 cycles, or PCSrc=11 -> curPC and retired unchanged; instValid stays 1.
- ROM word 32'hFC00_0000 at PC=12 with PCWre=1 -> next cycle halted=1, romRd=1, instValid=0, curPC=12, retired=4; state holds for 10 cycles.
- Reset pulsed low mid-cycle while in RUN at PC=40 -> curPC=0, retired=0, romRd=1 immediately; normal fetch resumes after release.
